axil_mem_responder: RTL and testbench
=====================================

// Module: axil_mem_responder
// PURPOSE
//  AXI-Lite subordinate backing memory: the far end of the cache's *_mng manager port.
//  Serves cache writebacks (AW/W/B) and line fetches (AR/R) from word storage.
//  Latency is programmable so cache miss/writeback paths can be exercised at realistic timing.
//  Holds one outstanding transaction at a time; used as next-level memory in cache benches.
// PARAMETERS
//  MEM_WORDS      4096  storage depth in 32-bit words; byte space = MEM_WORDS*4 starting at 0
//  READ_LATENCY   4     cycles from AR handshake to rvalid rising (legal range 1..255)
//  WRITE_LATENCY  2     cycles from the later of AW/W handshakes to bvalid rising (1..255)
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   asynchronous active-low reset
//  axil_awaddr_sbd  in  32  write address      | axil_awvalid_sbd in 1 | axil_awready_sbd out 1
//  axil_wdata_sbd   in  32  write data         | axil_wvalid_sbd  in 1 | axil_wready_sbd  out 1
//  axil_bresp_sbd   out 2   write response     | axil_bvalid_sbd  out 1 | axil_bready_sbd in 1
//  axil_araddr_sbd  in  32  read address       | axil_arvalid_sbd in 1 | axil_arready_sbd out 1
//  axil_rdata_sbd   out 32  read data          | axil_rresp_sbd   out 2 | axil_rvalid_sbd out 1
//  axil_rready_sbd  in  1   read response ready
// BEHAVIOUR
//  Reset: all ready/valid outputs 0, bresp/rresp 2'b00, rdata 0, state IDLE, counter 0.
//   Mid-operation reset drops the pending transaction at once; storage contents are kept.
//  FSM: IDLE -> WR_COLLECT -> WR_LAT -> B_RESP -> IDLE ; IDLE -> RD_LAT -> R_RESP -> IDLE.
//  All ready outputs are registered; handshake = valid & ready on a rising clk edge.
//  IDLE: awready=wready=1, arready=1. In any cycle where awvalid or wvalid is 1, arready
//   is driven 0 for the next cycle. Writes win over reads (writeback-before-fetch ordering).
//  AW and W are accepted independently, in either order or in the same cycle. Each ready
//   drops the cycle after its handshake. State is WR_COLLECT while only one has completed.
//  Once both AW and W have completed: go to WR_LAT and load counter=WRITE_LATENCY-1.
//   Storage is written on entry to WR_LAT.
//  WR_LAT: count down; at 0 go to B_RESP with bvalid=1. bvalid and bresp are held stable
//   until bready; on handshake go to IDLE.
//  AR handshake in IDLE: latch the address, go to RD_LAT with counter=READ_LATENCY-1.
//   The sram read is issued so data is valid in time. At 0 go to R_RESP with rvalid=1.
//   rdata and rresp are held stable until rready.
//  Address decode: word index = addr[2+:$clog2(MEM_WORDS)]; addr[1:0] is ignored.
//  addr >= MEM_WORDS*4 -> SLVERR (2'b10): a write is dropped, a read returns rdata=0.
//   All other accesses return OKAY (2'b00).
//  Latency of 1: valid rises the cycle after the final address/data handshake.
//  Back-to-back: after a B or R handshake, IDLE readies are high in the next cycle.
//   The minimum gap is therefore 1 idle cycle.
//  Valid outputs never depend combinationally on any ready input.
// CONFIGURATION
//  AXIL_MEM_RAND_STALL_EN defined: a 16-bit Fibonacci LFSR (seed 16'hACE1, taps 16,14,13,11)
//   advances every cycle. awready, wready and arready are additionally forced 0 whenever
//   lfsr[0]=1. The LFSR resets to its seed.
//  Undefined: no LFSR is present; readies follow the FSM rules above exactly.
// STRUCTURE
//  Package axil_pkg: resp_t enum (OKAY=2'b00, SLVERR=2'b10) and mem_state_t FSM enum.
//  Storage: one instance of the existing sram module, SIZE=MEM_WORDS, DATA_WIDTH=32.
//   The sram is written in WR_LAT entry and read in RD_LAT. No other sub-module is used.
//  Latency counter: 8 bits, shared by the read and write paths (only one is active at a time).
// TESTING
//  1 Write 0x1000 <- 0xDEADBEEF (AW and W same cycle), WRITE_LATENCY=2
//     -> bvalid 2 cycles later, bresp=00.
//    Then read 0x1000 -> rvalid READ_LATENCY cycles after AR, rdata=0xDEADBEEF, rresp=00.
//  2 W presented 3 cycles before AW -> wready drops after the W handshake, then AW accepted.
//     Single bvalid; the stored word matches.
//  3 arvalid and awvalid+wvalid raised in the same IDLE cycle -> write completes first
//     (arready=0 until B handshake). Read of the same address returns the new data.
//  4 Read addr MEM_WORDS*4 -> rresp=10, rdata=0. Write to it -> bresp=10;
//     word 0 is unchanged (no aliasing).
//  5 Hold bready=0 for 5 cycles -> bvalid/bresp stable, arready stays 0;
//     the next transaction is accepted 1 cycle after the handshake.
//  6 rst_n low during RD_LAT -> rvalid=0 immediately. After reset release,
//     a read of a previously written word returns the old value.

Source files
------------

// File: rtl/axil_pkg.sv
// +--------------------------------------------------------------------+
// | axil_pkg : shared response codes and FSM encoding for the          |
// |            AXI-Lite memory responder.                              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package axil_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WR_COLLECT = 3'd1,
      S_WR_LAT     = 3'd2,
      S_B_RESP     = 3'd3,
      S_RD_LAT     = 3'd4,
      S_R_RESP     = 3'd5
   } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/sram.sv
// +--------------------------------------------------------------------+
// | sram : simple dual-address word storage, registered read port.     |
// |        Read data holds its value while re is low.                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sram #(
   parameter int SIZE       = 4096,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = $clog2(SIZE)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] r_mem [SIZE];
   logic [DATA_WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
      if (re) begin
         r_rdata <= r_mem[raddr];
      end
   end

   assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/axil_mem_responder.sv
// +--------------------------------------------------------------------+
// | axil_mem_responder : AXI-Lite subordinate backing memory with      |
// |   programmable read/write latency, one transaction at a time.      |
// |   Option macro: AXIL_MEM_RAND_STALL_EN (LFSR-driven ready stalls). |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module axil_mem_responder
   import axil_pkg::*;
#(
   parameter int MEM_WORDS     = 4096,
   parameter int READ_LATENCY  = 4,
   parameter int WRITE_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] axil_awaddr_sbd,
   input  logic        axil_awvalid_sbd,
   output logic        axil_awready_sbd,
   input  logic [31:0] axil_wdata_sbd,
   input  logic        axil_wvalid_sbd,
   output logic        axil_wready_sbd,
   output logic [1:0]  axil_bresp_sbd,
   output logic        axil_bvalid_sbd,
   input  logic        axil_bready_sbd,
   input  logic [31:0] axil_araddr_sbd,
   input  logic        axil_arvalid_sbd,
   output logic        axil_arready_sbd,
   output logic [31:0] axil_rdata_sbd,
   output logic [1:0]  axil_rresp_sbd,
   output logic        axil_rvalid_sbd,
   input  logic        axil_rready_sbd
);

   localparam int          c_idx_w     = $clog2(MEM_WORDS);
   localparam logic [32:0] c_mem_bytes = 33'(MEM_WORDS) << 2;
   localparam logic [7:0]  c_wr_init   = 8'(WRITE_LATENCY - 1);
   localparam logic [7:0]  c_rd_init   = 8'(READ_LATENCY - 1);

   mem_state_t  r_state, w_state_n;
   logic [7:0]  r_cnt, w_cnt_n;
   logic        r_awready, r_wready, r_arready;
   logic        r_bvalid, r_rvalid, w_bvalid_n, w_rvalid_n;
   resp_t       r_bresp, r_rresp, w_bresp_n, w_rresp_n;
   logic        r_aw_done, r_w_done, w_aw_done_n, w_w_done_n;
   logic        r_wr_commit, w_commit_n;
   logic [31:0] r_waddr, r_wdata, r_raddr;
   logic        w_aw_hs, w_w_hs, w_ar_hs, w_wr_any;
   logic        w_wr_err, w_rd_err, w_stall;
   logic        w_awready_n, w_wready_n, w_arready_n;
   logic        w_sram_re;
   logic [31:0] w_sram_rdata;

   assign w_wr_any = axil_awvalid_sbd | axil_wvalid_sbd;
   assign w_aw_hs  = axil_awvalid_sbd & r_awready;
   assign w_w_hs   = axil_wvalid_sbd & r_wready;
   // Pending write traffic takes priority over a read offered in the same cycle.
   assign w_ar_hs  = (r_state == S_IDLE) & axil_arvalid_sbd & r_arready & ~w_wr_any;
   assign w_wr_err = ({1'b0, r_waddr} >= c_mem_bytes);
   assign w_rd_err = ({1'b0, r_raddr} >= c_mem_bytes);

   always_comb begin
      w_state_n   = r_state;
      w_cnt_n     = r_cnt;
      w_aw_done_n = r_aw_done | w_aw_hs;
      w_w_done_n  = r_w_done | w_w_hs;
      w_bvalid_n  = r_bvalid;
      w_rvalid_n  = r_rvalid;
      w_bresp_n   = r_bresp;
      w_rresp_n   = r_rresp;
      w_commit_n  = 1'b0;
      case (r_state)
         S_IDLE, S_WR_COLLECT: begin
            if (w_aw_done_n && w_w_done_n) begin
               w_state_n  = S_WR_LAT;
               w_cnt_n    = c_wr_init;
               w_commit_n = 1'b1;
            end else if (w_aw_done_n || w_w_done_n) begin
               w_state_n = S_WR_COLLECT;
            end else if (w_ar_hs) begin
               w_state_n = S_RD_LAT;
               w_cnt_n   = c_rd_init;
            end
         end
         S_WR_LAT: begin
            if (r_cnt == 8'd0) begin
               w_state_n  = S_B_RESP;
               w_bvalid_n = 1'b1;
               w_bresp_n  = w_wr_err ? SLVERR : OKAY;
            end else begin
               w_cnt_n = r_cnt - 8'd1;
            end
         end
         S_B_RESP: begin
            if (axil_bready_sbd) begin
               w_state_n  = S_IDLE;
               w_bvalid_n = 1'b0;
            end
         end
         S_RD_LAT: begin
            if (r_cnt == 8'd0) begin
               w_state_n  = S_R_RESP;
               w_rvalid_n = 1'b1;
               w_rresp_n  = w_rd_err ? SLVERR : OKAY;
            end else begin
               w_cnt_n = r_cnt - 8'd1;
            end
         end
         S_R_RESP: begin
            if (axil_rready_sbd) begin
               w_state_n  = S_IDLE;
               w_rvalid_n = 1'b0;
            end
         end
         default: w_state_n = S_IDLE;
      endcase
      if (w_state_n != S_WR_COLLECT) begin
         w_aw_done_n = 1'b0;
         w_w_done_n  = 1'b0;
      end
   end

   assign w_awready_n = ((w_state_n == S_IDLE) | ((w_state_n == S_WR_COLLECT) & ~w_aw_done_n)) & ~w_stall;
   assign w_wready_n  = ((w_state_n == S_IDLE) | ((w_state_n == S_WR_COLLECT) & ~w_w_done_n)) & ~w_stall;
   assign w_arready_n = (w_state_n == S_IDLE) & ~w_wr_any & ~w_stall;

`ifdef AXIL_MEM_RAND_STALL_EN
   logic [15:0] r_lfsr, w_lfsr_n;

   assign w_lfsr_n = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   assign w_stall  = w_lfsr_n[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= 16'hACE1;
      end else begin
         r_lfsr <= w_lfsr_n;
      end
   end
`else
   assign w_stall = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= 8'd0;
         r_awready   <= 1'b0;
         r_wready    <= 1'b0;
         r_arready   <= 1'b0;
         r_bvalid    <= 1'b0;
         r_rvalid    <= 1'b0;
         r_bresp     <= OKAY;
         r_rresp     <= OKAY;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_wr_commit <= 1'b0;
         r_waddr     <= 32'd0;
         r_wdata     <= 32'd0;
         r_raddr     <= 32'd0;
      end else begin
         r_state     <= w_state_n;
         r_cnt       <= w_cnt_n;
         r_awready   <= w_awready_n;
         r_wready    <= w_wready_n;
         r_arready   <= w_arready_n;
         r_bvalid    <= w_bvalid_n;
         r_rvalid    <= w_rvalid_n;
         r_bresp     <= w_bresp_n;
         r_rresp     <= w_rresp_n;
         r_aw_done   <= w_aw_done_n;
         r_w_done    <= w_w_done_n;
         r_wr_commit <= w_commit_n;
         if (w_aw_hs) r_waddr <= axil_awaddr_sbd;
         if (w_w_hs)  r_wdata <= axil_wdata_sbd;
         if (w_ar_hs) r_raddr <= axil_araddr_sbd;
      end
   end

   // The read fires on the last latency cycle; its registered output then holds through R_RESP.
   assign w_sram_re = (r_state == S_RD_LAT) && (r_cnt == 8'd0);

   sram #(
      .SIZE       (MEM_WORDS),
      .DATA_WIDTH (32)
   ) u_sram (
      .clk   (clk),
      .we    (r_wr_commit & ~w_wr_err),
      .waddr (r_waddr[2 +: c_idx_w]),
      .wdata (r_wdata),
      .re    (w_sram_re),
      .raddr (r_raddr[2 +: c_idx_w]),
      .rdata (w_sram_rdata)
   );

   assign axil_awready_sbd = r_awready;
   assign axil_wready_sbd  = r_wready;
   assign axil_arready_sbd = r_arready;
   assign axil_bvalid_sbd  = r_bvalid;
   assign axil_bresp_sbd   = r_bresp;
   assign axil_rvalid_sbd  = r_rvalid;
   assign axil_rresp_sbd   = r_rresp;
   assign axil_rdata_sbd   = (r_rvalid && (r_rresp == OKAY)) ? w_sram_rdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_axil_mem_responder.sv
// +--------------------------------------------------------------------+
// | tb_axil_mem_responder : directed bench for axil_mem_responder.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_axil_mem_responder;

   localparam int          RL  = 4;
   localparam int          WL  = 2;
   localparam logic [31:0] OOR = 32'h0000_4000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   axil_mem_responder #(
      .MEM_WORDS     (4096),
      .READ_LATENCY  (RL),
      .WRITE_LATENCY (WL)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .axil_awaddr_sbd  (awaddr),
      .axil_awvalid_sbd (awvalid),
      .axil_awready_sbd (awready),
      .axil_wdata_sbd   (wdata),
      .axil_wvalid_sbd  (wvalid),
      .axil_wready_sbd  (wready),
      .axil_bresp_sbd   (bresp),
      .axil_bvalid_sbd  (bvalid),
      .axil_bready_sbd  (bready),
      .axil_araddr_sbd  (araddr),
      .axil_arvalid_sbd (arvalid),
      .axil_arready_sbd (arready),
      .axil_rdata_sbd   (rdata),
      .axil_rresp_sbd   (rresp),
      .axil_rvalid_sbd  (rvalid),
      .axil_rready_sbd  (rready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, output bit ok);
      bit aw_ok = 1'b0;
      bit w_ok  = 1'b0;
      awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
      for (int i = 0; i < 100 && !(aw_ok && w_ok); i++) begin
         if (awvalid && awready) aw_ok = 1'b1;
         if (wvalid && wready)   w_ok  = 1'b1;
         tick();
         if (aw_ok) awvalid = 1'b0;
         if (w_ok)  wvalid  = 1'b0;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      ok = aw_ok && w_ok;
   endtask

   task automatic send_ar(input logic [31:0] a, output bit ok);
      ok = 1'b0; araddr = a; arvalid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (arready) ok = 1'b1;
         tick();
      end
      arvalid = 1'b0;
   endtask

   task automatic wait_b(output int lat, output bit ok);
      lat = 0;
      while (!bvalid && lat < 300) begin tick(); lat++; end
      ok = bvalid;
   endtask

   task automatic wait_r(output int lat, output bit ok);
      lat = 0;
      while (!rvalid && lat < 300) begin tick(); lat++; end
      ok = rvalid;
   endtask

   task automatic b_accept();
      bready = 1'b1; tick(); bready = 1'b0;
   endtask

   task automatic r_accept();
      rready = 1'b1; tick(); rready = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           output logic [1:0] resp, output int lat, output bit ok);
      bit ok1, ok2;
      send_aw_w(a, d, ok1);
      wait_b(lat, ok2);
      resp = bresp;
      if (ok2) b_accept();
      ok = ok1 && ok2;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                          output logic [1:0] resp, output int lat, output bit ok);
      bit ok1, ok2;
      send_ar(a, ok1);
      wait_r(lat, ok2);
      data = rdata; resp = rresp;
      if (ok2) r_accept();
      ok = ok1 && ok2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_checks++; if ({awready, wready, arready} !== 3'b000) $display("FAIL reset_readies: got %b expected 000", {awready, wready, arready}); else n_pass++;
      n_checks++; if ({bvalid, rvalid} !== 2'b00) $display("FAIL reset_valids: got %b expected 00", {bvalid, rvalid}); else n_pass++;
      n_checks++; if ({bresp, rresp} !== 4'b0000) $display("FAIL reset_resps: got %b expected 0000", {bresp, rresp}); else n_pass++;
      n_checks++; if (rdata !== 32'd0) $display("FAIL reset_rdata: got %h expected 00000000", rdata); else n_pass++;
      rst_n = 1'b1;
      tick();
      n_checks++; if ({awready, wready, arready} !== 3'b111) $display("FAIL idle_readies: got %b expected 111", {awready, wready, arready}); else n_pass++;
   endtask

   task automatic test_write_read();
      logic [1:0] resp; logic [31:0] data; int lat; bit ok;
      do_write(32'h1000, 32'hDEADBEEF, resp, lat, ok);
      n_checks++; if (!ok) $display("FAIL wr1_done: got timeout expected bvalid"); else n_pass++;
      n_checks++; if (lat !== WL) $display("FAIL wr1_latency: got %0d expected %0d", lat, WL); else n_pass++;
      n_checks++; if (resp !== 2'b00) $display("FAIL wr1_bresp: got %b expected 00", resp); else n_pass++;
      do_read(32'h1000, data, resp, lat, ok);
      n_checks++; if (!ok) $display("FAIL rd1_done: got timeout expected rvalid"); else n_pass++;
      n_checks++; if (lat !== RL) $display("FAIL rd1_latency: got %0d expected %0d", lat, RL); else n_pass++;
      n_checks++; if (data !== 32'hDEADBEEF) $display("FAIL rd1_rdata: got %h expected deadbeef", data); else n_pass++;
      n_checks++; if (resp !== 2'b00) $display("FAIL rd1_rresp: got %b expected 00", resp); else n_pass++;
   endtask

   task automatic test_w_before_aw();
      logic [1:0] resp; logic [31:0] data; int lat; bit ok; int extra_b;
      wdata = 32'h12345678; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      n_checks++; if ({wready, awready} !== 2'b01) $display("FAIL wfirst_readies: got %b expected 01", {wready, awready}); else n_pass++;
      tick(); tick();
      n_checks++; if (wready !== 1'b0) $display("FAIL wfirst_wready_held: got %b expected 0", wready); else n_pass++;
      awaddr = 32'h0000_0020; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      wait_b(lat, ok);
      n_checks++; if (!ok || lat !== WL) $display("FAIL wfirst_b_latency: got %0d expected %0d", lat, WL); else n_pass++;
      b_accept();
      extra_b = 0;
      repeat (4) begin if (bvalid) extra_b++; tick(); end
      n_checks++; if (extra_b !== 0) $display("FAIL wfirst_single_b: got %0d extra bvalid cycles expected 0", extra_b); else n_pass++;
      do_read(32'h0000_0020, data, resp, lat, ok);
      n_checks++; if (!ok || data !== 32'h12345678) $display("FAIL wfirst_rdata: got %h expected 12345678", data); else n_pass++;
   endtask

   task automatic test_write_priority();
      logic [31:0] data; int lat; bit ok; bit ar_leak; bit r_early;
      araddr = 32'h2000; arvalid = 1'b1;
      send_aw_w(32'h2000, 32'hCAFEF00D, ok);
      arvalid = 1'b1;
      ar_leak = 1'b0; r_early = 1'b0;
      for (int i = 0; i < 100 && !bvalid; i++) begin
         if (arready) ar_leak = 1'b1;
         if (rvalid)  r_early = 1'b1;
         tick();
      end
      n_checks++; if (!bvalid) $display("FAIL prio_b: got bvalid=0 expected 1"); else n_pass++;
      n_checks++; if ({ar_leak, r_early} !== 2'b00) $display("FAIL prio_ar_blocked: got arready/rvalid seen=%b expected 00", {ar_leak, r_early}); else n_pass++;
      b_accept();
      n_checks++; if (arready !== 1'b1) $display("FAIL prio_arready_after_b: got %b expected 1", arready); else n_pass++;
      send_ar(32'h2000, ok);
      wait_r(lat, ok);
      data = rdata;
      if (ok) r_accept();
      n_checks++; if (!ok || data !== 32'hCAFEF00D) $display("FAIL prio_rdata: got %h expected cafef00d", data); else n_pass++;
   endtask

   task automatic test_slverr();
      logic [1:0] resp; logic [31:0] data; int lat; bit ok;
      do_write(32'h0, 32'h0BADCAFE, resp, lat, ok);
      do_read(OOR, data, resp, lat, ok);
      n_checks++; if (!ok || resp !== 2'b10) $display("FAIL oor_rresp: got %b expected 10", resp); else n_pass++;
      n_checks++; if (data !== 32'd0) $display("FAIL oor_rdata: got %h expected 00000000", data); else n_pass++;
      do_write(OOR, 32'hFFFFFFFF, resp, lat, ok);
      n_checks++; if (!ok || resp !== 2'b10) $display("FAIL oor_bresp: got %b expected 10", resp); else n_pass++;
      do_read(32'h0, data, resp, lat, ok);
      n_checks++; if (!ok || data !== 32'h0BADCAFE || resp !== 2'b00) $display("FAIL oor_no_alias: got %h/%b expected 0badcafe/00", data, resp); else n_pass++;
   endtask

   task automatic test_bready_hold();
      logic [1:0] resp; logic [31:0] data; int lat; bit ok; bit unstable;
      send_aw_w(32'h30, 32'h55AA55AA, ok);
      wait_b(lat, ok);
      unstable = 1'b0;
      repeat (5) begin
         if (bvalid !== 1'b1 || bresp !== 2'b00 || arready !== 1'b0 || awready !== 1'b0) unstable = 1'b1;
         tick();
      end
      n_checks++; if (!ok || unstable) $display("FAIL bhold_stable: got unstable=%b expected 0", unstable); else n_pass++;
      b_accept();
      n_checks++; if ({awready, wready, arready} !== 3'b111) $display("FAIL bhold_b2b_readies: got %b expected 111", {awready, wready, arready}); else n_pass++;
      do_read(32'h30, data, resp, lat, ok);
      n_checks++; if (!ok || data !== 32'h55AA55AA) $display("FAIL bhold_rdata: got %h expected 55aa55aa", data); else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      logic [1:0] resp; logic [31:0] data; int lat; bit ok; bit seen_valid;
      send_ar(32'h1000, ok);
      tick();
      rst_n = 1'b0;
      #1;
      n_checks++; if ({rvalid, arready, awready} !== 3'b000) $display("FAIL midrst_outputs: got %b expected 000", {rvalid, arready, awready}); else n_pass++;
      seen_valid = 1'b0;
      repeat (RL + 2) begin tick(); if (rvalid) seen_valid = 1'b1; end
      n_checks++; if (seen_valid) $display("FAIL midrst_no_rvalid: got rvalid=1 expected 0"); else n_pass++;
      rst_n = 1'b1;
      tick();
      do_read(32'h1000, data, resp, lat, ok);
      n_checks++; if (!ok || data !== 32'hDEADBEEF || resp !== 2'b00) $display("FAIL midrst_storage: got %h/%b expected deadbeef/00", data, resp); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_w_before_aw();
      test_write_priority();
      test_slverr();
      test_bready_hold();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
